// File: rtl/cdnsusbhs_data_sync_rx_mc.sv
// -----------------------------------------------------------------------------
// cdnsusbhs_data_sync_rx_mc
//
// Receive half of a multi-channel two-phase (toggle) request/ack data
// synchroniser. Everything here runs on rxclk.
//
// Each channel's request toggle is brought into the rxclk domain through a
// SYNC_STAGES-deep flop chain. A change on the synchronised request captures
// that channel's data word into a per-channel holding register. Pending
// channels are merged round-robin into one registered valid/ready stream
// tagged with the source channel. A channel's ack toggles when its holding
// register is loaded into the output register, which frees it for the next
// word.
//
// Ports
//   rxclk      receive-domain clock
//   rxrst      asynchronous, active-low reset
//   cdc_req    per-channel request toggles (asynchronous to rxclk)
//   cdc_data   per-channel data words, channel n at [n*W +: W]; stable from
//              before the req toggle until the matching ack toggle
//   cdc_ack    per-channel ack toggles (registered)
//   rxdata     delivered word
//   rxchan     channel that rxdata came from
//   rxvalid    rxdata/rxchan valid
//   rxready    downstream accepts when rxvalid & rxready
//   proto_err  sticky per-channel flag: tx toggled again before its ack
// -----------------------------------------------------------------------------
module cdnsusbhs_data_sync_rx_mc #(
  parameter int unsigned DATA_SYNC_WIDTH = 32'd32,
  parameter int unsigned CHANNELS        = 32'd4,
  parameter int unsigned CHAN_WIDTH      = 32'd2,
  parameter int unsigned SYNC_STAGES     = 32'd2
) (
  input  logic                                rxclk,
  input  logic                                rxrst,
  input  logic [CHANNELS-1:0]                 cdc_req,
  input  logic [CHANNELS*DATA_SYNC_WIDTH-1:0] cdc_data,
  output logic [CHANNELS-1:0]                 cdc_ack,
  output logic [DATA_SYNC_WIDTH-1:0]          rxdata,
  output logic [CHAN_WIDTH-1:0]               rxchan,
  output logic                                rxvalid,
  input  logic                                rxready,
  output logic [CHANNELS-1:0]                 proto_err
);

  localparam int unsigned W = DATA_SYNC_WIDTH;

  // The pointer starts on the last channel so that channel 0 wins first.
  localparam logic [CHAN_WIDTH-1:0] RR_RESET = CHAN_WIDTH'(CHANNELS - 1);

  // ---------------------------------------------------------------------------
  // Request synchronisers
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] reqs;

  // NOTE: every clocked block uses non-blocking assignments so that each
  // stage samples the previous stage's value from before the edge.
  always_ff @(posedge rxclk or negedge rxrst) begin
    if (!rxrst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= cdc_req;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign reqs = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-channel capture state
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] req_seen;   // last request level already captured
  logic [CHANNELS-1:0] pend;       // holding register full, awaiting grant
  logic [CHANNELS-1:0] req_chg;    // new toggle seen on the synchronised req
  logic [CHANNELS-1:0] capture;
  logic [CHANNELS-1:0] grant_oh;   // one-hot of the channel loaded this cycle
  logic [CHANNELS-1:0] pend_nxt;
  logic [W-1:0]        hold [CHANNELS];

  assign req_chg = reqs ^ req_seen;

  // A toggle that arrives while the channel is still pending is left
  // unacknowledged in req_chg; it is captured as soon as pend drops.
  assign capture = req_chg & ~pend;

  // Capture needs pend=0 and a grant needs pend=1, so one channel never
  // sees both in the same cycle; other channels are independent.
  assign pend_nxt = (pend & ~grant_oh) | capture;

  // NOTE: the holding registers are reset along with the control state so
  // that rxdata can never expose stale contents from before a reset.
  always_ff @(posedge rxclk or negedge rxrst) begin
    if (!rxrst) begin
      req_seen  <= '0;
      pend      <= '0;
      proto_err <= '0;
      for (int n = 0; n < int'(CHANNELS); n++) begin
        hold[n] <= '0;
      end
    end else begin
      // capture implies req_chg, so flipping those bits aligns with reqs
      req_seen  <= req_seen ^ capture;
      pend      <= pend_nxt;
      proto_err <= proto_err | (req_chg & pend);
      for (int n = 0; n < int'(CHANNELS); n++) begin
        if (capture[n]) begin
          hold[n] <= cdc_data[n*int'(W) +: W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending channel strictly after rr_ptr
  // ---------------------------------------------------------------------------
  logic [CHAN_WIDTH-1:0] rr_ptr;
  logic [CHAN_WIDTH-1:0] grant;
  logic [CHAN_WIDTH-1:0] idx;
  logic                  grant_vld;
  logic                  load;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    // Walk from the farthest candidate to the nearest; the last pending hit
    // is the one closest after rr_ptr.
    for (int i = int'(CHANNELS); i >= 1; i--) begin
      idx = CHAN_WIDTH'((int'(rr_ptr) + i) % int'(CHANNELS));
      if (pend[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // The output register is free when empty or being drained this cycle.
  assign load     = grant_vld & (~rxvalid | rxready);
  assign grant_oh = load ? (CHANNELS'(1) << grant) : '0;

  // ---------------------------------------------------------------------------
  // Output register, ack toggles and arbitration pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge rxclk or negedge rxrst) begin
    if (!rxrst) begin
      rxvalid <= 1'b0;
      rxdata  <= '0;
      rxchan  <= '0;
      cdc_ack <= '0;
      rr_ptr  <= RR_RESET;
    end else if (load) begin
      rxvalid <= 1'b1;
      rxdata  <= hold[grant];
      rxchan  <= grant;
      cdc_ack <= cdc_ack ^ grant_oh;
      rr_ptr  <= grant;
    end else if (rxvalid && rxready) begin
      // word taken and nothing else pending; rxdata/rxchan keep their values
      rxvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdnsusbhs_data_sync_rx_mc.sv
// -----------------------------------------------------------------------------
// tb_cdnsusbhs_data_sync_rx_mc
//
// Self-checking bench for cdnsusbhs_data_sync_rx_mc (default parameters).
// A transaction-level reference keeps, per channel, the ordered list of words
// the transmit side has sent. A monitor running on the falling edge checks
// every accepted word against that list, checks that stalled outputs hold,
// that rxchan stays in range, and that each ack line's parity equals the
// number of words taken out of that channel's holding register. Directed
// sequences check exact latency, round-robin order, stalls, protocol errors
// and mid-operation reset; a randomized phase drives legal traffic.
// -----------------------------------------------------------------------------
module tb_cdnsusbhs_data_sync_rx_mc;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int SB_DEPTH = 1024;

  logic            rxclk;
  logic            rxrst;
  logic [CH-1:0]   cdc_req;
  logic [CH*W-1:0] cdc_data;
  logic [CH-1:0]   cdc_ack;
  logic [W-1:0]    rxdata;
  logic [CW-1:0]   rxchan;
  logic            rxvalid;
  logic            rxready;
  logic [CH-1:0]   proto_err;

  cdnsusbhs_data_sync_rx_mc #(
    .DATA_SYNC_WIDTH(32'd32),
    .CHANNELS       (32'd4),
    .CHAN_WIDTH     (32'd2),
    .SYNC_STAGES    (32'd2)
  ) dut (
    .rxclk    (rxclk),
    .rxrst    (rxrst),
    .cdc_req  (cdc_req),
    .cdc_data (cdc_data),
    .cdc_ack  (cdc_ack),
    .rxdata   (rxdata),
    .rxchan   (rxchan),
    .rxvalid  (rxvalid),
    .rxready  (rxready),
    .proto_err(proto_err)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference: per-channel ordered list of sent words
  // ---------------------------------------------------------------------------
  logic [W-1:0] sb_mem [CH][SB_DEPTH];
  int           sb_wr  [CH];   // written by stimulus only
  int           sb_rd  [CH];   // written by monitor only
  int           acc_cnt[CH];   // words accepted downstream per channel

  function automatic bit sb_empty();
    bit e = 1'b1;
    for (int c = 0; c < CH; c++) if (sb_rd[c] != sb_wr[c]) e = 1'b0;
    return e;
  endfunction

  // Transmit side: present the word and toggle the request.
  task automatic send(input int ch, input logic [W-1:0] d);
    cdc_data[ch*W +: W] = d;
    cdc_req[ch] = ~cdc_req[ch];
    sb_mem[ch][sb_wr[ch] % SB_DEPTH] = d;
    sb_wr[ch]++;
  endtask

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic do_reset();
    rxrst   = 1'b0;
    cdc_req = '0;
    rxready = 1'b0;
    repeat (3) @(posedge rxclk);
    #1 rxrst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor (falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  logic            prev_stall;
  logic [CW+W-1:0] prev_out;

  initial begin
    logic [CH-1:0] exp_ack;
    int            c;
    int            loads;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int i = 0; i < CH; i++) begin
      sb_rd[i]   = 0;
      acc_cnt[i] = 0;
    end
    forever begin
      @(negedge rxclk);
      if (!rxrst) begin
        // anything in flight is lost across a reset
        for (int i = 0; i < CH; i++) begin
          sb_rd[i]   = sb_wr[i];
          acc_cnt[i] = 0;
        end
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", 64'({rxvalid, rxchan, rxdata}), 64'({1'b1, prev_out}));
        end
        for (int i = 0; i < CH; i++) begin
          loads = acc_cnt[i] + ((rxvalid && int'(rxchan) == i) ? 1 : 0);
          exp_ack[i] = ((loads % 2) == 1);
        end
        check("ack_parity", 64'(cdc_ack), 64'(exp_ack));
        if (rxvalid) begin
          check("chan_range", 64'(int'(rxchan) < CH), 64'd1);
          if (rxready) begin
            c = int'(rxchan);
            check("word_expected", 64'(sb_rd[c] != sb_wr[c]), 64'd1);
            if (sb_rd[c] != sb_wr[c]) begin
              check("word_data", 64'(rxdata), 64'(sb_mem[c][sb_rd[c] % SB_DEPTH]));
              sb_rd[c]++;
            end
            acc_cnt[c]++;
          end
        end
        prev_stall = rxvalid && !rxready;
        prev_out   = {rxchan, rxdata};
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           cnt;
    int           first_e;
    int           last_e;
    int           k;
    logic [CW-1:0] order [4];
    logic [W-1:0]  got1 [4];

    for (int i = 0; i < CH; i++) sb_wr[i] = 0;
    rxrst    = 1'b0;
    cdc_req  = '0;
    cdc_data = '0;
    rxready  = 1'b0;

    // ---- reset release, idle --------------------------------------------
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", 64'({cdc_ack, rxvalid, proto_err}), 64'd0);
    end

    // ---- single word latency on channel 2 ------------------------------
    do_reset();
    rxready = 1'b1;
    send(2, 32'hDEADBEEF);
    repeat (3) tick();
    check("lat_pre_valid", 64'(rxvalid), 64'd0);
    check("lat_pre_ack", 64'(cdc_ack[2]), 64'd0);
    tick();
    check("lat_valid", 64'(rxvalid), 64'd1);
    check("lat_data", 64'(rxdata), 64'h0000_0000_DEAD_BEEF);
    check("lat_chan", 64'(rxchan), 64'd2);
    check("lat_ack", 64'(cdc_ack), 64'b0100);
    tick();
    check("lat_drop", 64'(rxvalid), 64'd0);

    // ---- round robin: all four at once, then 1 and 3 -------------------
    do_reset();
    rxready = 1'b1;
    for (int i = 0; i < CH; i++) send(i, W'(i));
    cnt = 0; first_e = 0; last_e = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (rxvalid) begin
        if (cnt < 4) order[cnt] = rxchan;
        if (cnt == 0) first_e = e;
        last_e = e;
        cnt++;
      end
    end
    check("rr4_count", 64'(cnt), 64'd4);
    check("rr4_first", 64'(first_e), 64'd4);
    check("rr4_span", 64'(last_e - first_e), 64'd3);
    for (int i = 0; i < 4; i++) check("rr4_order", 64'(order[i]), 64'(i));

    send(1, 32'h11);
    send(3, 32'h33);
    cnt = 0; first_e = 0; last_e = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (rxvalid) begin
        if (cnt < 4) order[cnt] = rxchan;
        if (cnt == 0) first_e = e;
        last_e = e;
        cnt++;
      end
    end
    check("rr2_count", 64'(cnt), 64'd2);
    check("rr2_span", 64'(last_e - first_e), 64'd1);
    check("rr2_order0", 64'(order[0]), 64'd1);
    check("rr2_order1", 64'(order[1]), 64'd3);

    // ---- stall on channel 0 with a second word pending ----------------
    do_reset();
    rxready = 1'b0;
    send(0, 32'hA5A5A5A5);
    repeat (4) tick();
    check("stall_valid", 64'(rxvalid), 64'd1);
    check("stall_data", 64'(rxdata), 64'h0000_0000_A5A5_A5A5);
    send(0, 32'h5A5A5A5A);
    repeat (10) tick();
    check("stall_out", 64'({rxvalid, rxchan, rxdata}), 64'({1'b1, 2'd0, 32'hA5A5A5A5}));
    check("stall_ack_once", 64'(cdc_ack), 64'b0001);
    rxready = 1'b1;
    tick();
    check("stall_second", 64'({rxvalid, rxchan, rxdata}), 64'({1'b1, 2'd0, 32'h5A5A5A5A}));
    check("stall_ack_twice", 64'(cdc_ack), 64'b0000);
    tick();
    check("stall_drop", 64'(rxvalid), 64'd0);

    // ---- randomized legal traffic -------------------------------------
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      rxready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CH; c++) begin
        if (cdc_ack[c] == cdc_req[c] && $urandom_range(0, 4) == 0) begin
          send(c, $urandom);
        end
      end
    end
    rxready = 1'b1;
    k = 0;
    while (k < 400 && !(sb_empty() && !rxvalid)) begin
      tick();
      k++;
    end
    check("rand_drain", 64'(k < 400), 64'd1);
    check("rand_no_proto", 64'(proto_err), 64'd0);

    // ---- protocol error: channel 1 toggles twice during a stall -------
    do_reset();
    rxready = 1'b0;
    send(0, 32'hC0C00000);
    repeat (4) tick();
    send(1, 32'h11110001);
    repeat (5) tick();
    check("proto_clean", 64'(proto_err), 64'd0);
    send(1, 32'h11110002);
    repeat (5) tick();
    check("proto_set", 64'(proto_err), 64'b0010);
    repeat (3) tick();
    check("proto_sticky", 64'(proto_err), 64'b0010);
    rxready = 1'b1;
    cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (rxvalid && rxchan == 2'd1) begin
        if (cnt < 4) got1[cnt] = rxdata;
        cnt++;
      end
    end
    check("proto_count", 64'(cnt), 64'd2);
    check("proto_word0", 64'(got1[0]), 64'h0000_0000_1111_0001);
    check("proto_word1", 64'(got1[1]), 64'h0000_0000_1111_0002);
    check("proto_after", 64'(proto_err), 64'b0010);

    // ---- mid-operation reset ------------------------------------------
    rxready = 1'b0;
    send(2, 32'h22222222);
    repeat (4) tick();
    check("mid_pre_valid", 64'(rxvalid), 64'd1);
    #3;
    rxrst   = 1'b0;
    cdc_req = '0;
    #1;
    check("mid_rst_valid", 64'(rxvalid), 64'd0);
    check("mid_rst_data", 64'({rxchan, rxdata}), 64'd0);
    check("mid_rst_ack", 64'(cdc_ack), 64'd0);
    check("mid_rst_proto", 64'(proto_err), 64'd0);
    repeat (2) @(posedge rxclk);
    #1 rxrst = 1'b1;
    rxready = 1'b1;
    send(3, 32'h33330003);
    repeat (4) tick();
    check("post_rst_word", 64'({rxvalid, rxchan, rxdata}), 64'({1'b1, 2'd3, 32'h33330003}));
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
